// File: rtl/pwm_pkg.sv
// Shared types and constant helpers for the pwm_fade_array channel slice.
// Used by both the top and the per-channel module.
package pwm_pkg;

    localparam int PWM_MAX_RES  = 16;
    localparam int PWM_MAX_STEP = 16;

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int period_max(input int res);
        return (1 << res) - 1;
    endfunction

    // Shadow register for a channel. Fields are sized for the widest supported build.
    // Each channel uses only the low RES / STEP_W bits.
    typedef struct packed {
        logic [PWM_MAX_RES-1:0]  duty;
        logic [PWM_MAX_STEP-1:0] step;
        logic                    pending;
    } pwm_shadow_t;

endpackage

// File: rtl/pwm_fade_channel.sv
// One PWM channel: shadow register, target/current duty, optional fade engine, output compare.
// The fade engine is built only when PWM_FADE_EN is defined.
module pwm_fade_channel
    import pwm_pkg::*;
#(
    parameter int RES    = 8,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              boundary,
    input  logic              wr,
    input  logic [RES-1:0]    wr_duty,
    input  logic [STEP_W-1:0] wr_step,
    input  logic [RES-1:0]    cnt,
    output logic              pending,
    output logic              pwm_out,
    output logic              fade_done
);

    pwm_shadow_t    shadow_q, shadow_d;
    logic [RES-1:0] tgt_q, tgt_d;
    logic [RES-1:0] cur_q, cur_d;
    logic           pwm_out_q, pwm_out_d;
    logic           fade_done_q, fade_done_d;
    logic           load;
    logic [RES-1:0] load_duty;

    assign load      = boundary & shadow_q.pending;
    assign load_duty = shadow_q.duty[RES-1:0];

    // Boundary clears pending first, so a write in the boundary clk stays pending for the next one.
    always_comb begin
        shadow_d = shadow_q;
        if (load) shadow_d.pending = 1'b0;
        if (wr) begin
            shadow_d.duty    = PWM_MAX_RES'(wr_duty);
`ifdef PWM_FADE_EN
            shadow_d.step    = PWM_MAX_STEP'(wr_step);
`endif
            shadow_d.pending = 1'b1;
        end
    end

`ifdef PWM_FADE_EN
    localparam int AW = (RES + 1 > STEP_W) ? RES + 1 : STEP_W;

    logic [STEP_W-1:0] step_q, step_d;
    logic [AW-1:0]     diff, step_x;

    // Fade uses the freshly loaded target/step and clamps to the target when the step covers the gap.
    always_comb begin
        tgt_d  = load ? load_duty : tgt_q;
        step_d = load ? shadow_q.step[STEP_W-1:0] : step_q;
        step_x = AW'(step_d);
        diff   = (tgt_d >= cur_q) ? (AW'(tgt_d) - AW'(cur_q)) : (AW'(cur_q) - AW'(tgt_d));
        cur_d  = cur_q;
        if (boundary) begin
            if (step_d == '0 || step_x >= diff) cur_d = tgt_d;
            else if (tgt_d > cur_q)             cur_d = RES'(AW'(cur_q) + step_x);
            else                                cur_d = RES'(AW'(cur_q) - step_x);
        end
        fade_done_d = (cur_q == tgt_q);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) step_q <= '0;
        else            step_q <= step_d;
    end
`else
    logic unused_step;
    assign unused_step = ^wr_step;

    always_comb begin
        tgt_d       = load ? load_duty : tgt_q;
        cur_d       = load ? load_duty : cur_q;
        fade_done_d = (cur_q == tgt_q) & ~load;
    end
`endif

    assign pwm_out_d = en & (cur_q > cnt);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_q    <= '0;
            tgt_q       <= '0;
            cur_q       <= '0;
            pwm_out_q   <= 1'b0;
            fade_done_q <= 1'b1;
        end else begin
            shadow_q    <= shadow_d;
            tgt_q       <= tgt_d;
            cur_q       <= cur_d;
            pwm_out_q   <= pwm_out_d;
            fade_done_q <= fade_done_d;
        end
    end

    assign pending   = shadow_q.pending;
    assign pwm_out   = pwm_out_q;
    assign fade_done = fade_done_q;

endmodule

// File: rtl/pwm_fade_array.sv
// pwm_fade_array: N-channel PWM driver with shadowed duty writes applied on period boundaries.
// Define PWM_FADE_EN to build the per-channel linear fade engine.
module pwm_fade_array
    import pwm_pkg::*;
#(
    parameter int  N_CH   = 3,
    parameter int  RES    = 8,
    parameter int  PRESC  = 1,
    parameter int  STEP_W = 8,
    localparam int CH_W   = ch_w(N_CH)
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [RES-1:0]    cfg_duty,
    input  logic [STEP_W-1:0] cfg_step,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_tk,
    output logic [N_CH-1:0]   fade_done
);

    localparam int             PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int             NSLOT      = 1 << CH_W;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC - 1);
    localparam logic [RES-1:0] CNT_LAST   = RES'(period_max(RES) - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [RES-1:0]   cnt_q, cnt_d;
    logic             period_tk_q, period_tk_d;
    logic             tick, boundary;
    logic [N_CH-1:0]  pending, wr;
    logic [NSLOT-1:0] pending_ext;

    assign tick     = en & (presc_q == PRESC_LAST);
    assign boundary = tick & (cnt_q == CNT_LAST);

    always_comb begin
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        if (en)   presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        if (tick) cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + RES'(1);
        period_tk_d = boundary;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            period_tk_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            period_tk_q <= period_tk_d;
        end
    end

    // Unused channel slots read as not pending, so out-of-range writes are accepted and dropped.
    assign pending_ext = NSLOT'(pending);
    assign cfg_ready   = ~pending_ext[cfg_ch];
    assign period_tk   = period_tk_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

        pwm_fade_channel #(
            .RES    (RES),
            .STEP_W (STEP_W)
        ) u_ch (
            .clk       (clk),
            .sys_rst_n (sys_rst_n),
            .en        (en),
            .boundary  (boundary),
            .wr        (wr[i]),
            .wr_duty   (cfg_duty),
            .wr_step   (cfg_step),
            .cnt       (cnt_q),
            .pending   (pending[i]),
            .pwm_out   (pwm_out[i]),
            .fade_done (fade_done[i])
        );
    end

endmodule
